// File: rtl/bcd_seq_pkg.sv
// Shared constants for the binary-to-BCD conversion sequencer: state encoding,
// digit-adjust constants and an elaboration-time range check.
package bcd_seq_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [3:0] ADJ_THRESH = 4'd5;
   localparam logic [3:0] ADJ_ADD    = 4'd3;

   // True when 10^digits > 2^bin_w - 1, i.e. every input fits in the BCD field.
   // Widths of 60 bits or more are rejected to keep the arithmetic in 64 bits.
   function automatic bit digits_cover(int unsigned bin_w, int unsigned digits);
      longint unsigned pow10;
      longint unsigned maxv;
      pow10 = 64'd1;
      if (bin_w >= 60) return 1'b0;
      maxv = (64'd1 << bin_w) - 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
         if (pow10 > maxv) return 1'b1;
         pow10 = pow10 * 64'd10;
      end
      return pow10 > maxv;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the shift-and-add-3 step: adds 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
   import bcd_seq_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bcd_convert_sequencer.sv
// Multi-cycle binary-to-BCD converter (one bit per clock, MSB first) with a
// start/busy/done handshake, a held result and a significant-digit count.
module bcd_convert_sequencer
   import bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W  = 31,
   parameter int unsigned DIGITS = 10
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [BIN_W-1:0]             bin_in,
   output logic                         ready,
   output logic                         busy,
   output logic                         done,
   output logic [4*DIGITS-1:0]          bcd_out,
   output logic [$clog2(DIGITS+1)-1:0]  ndigits
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam int unsigned ND_W  = $clog2(DIGITS + 1);
   localparam int unsigned BCD_W = 4 * DIGITS;

   if (!digits_cover(BIN_W, DIGITS)) begin : g_bad_digits
      $error("bcd_convert_sequencer: DIGITS too small to hold a BIN_W-bit value");
   end

   logic [1:0]       state_q;
   logic [BIN_W-1:0] bin_shift_q;
   logic [BIN_W-1:0] bin_next;
   logic [BCD_W-1:0] bcd_work_q;
   logic [BCD_W-1:0] bcd_adj;
   logic [BCD_W-1:0] bcd_next;
   logic [CNT_W-1:0] cnt_q;
   logic [BCD_W-1:0] bcd_out_q;
   logic [ND_W-1:0]  ndigits_q;
   logic [ND_W-1:0]  nd_calc;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .din  (bcd_work_q[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   // Adjusted digits and the remaining binary bits shift together as one register.
   always_comb begin
      {bcd_next, bin_next} = {bcd_adj, bin_shift_q} << 1;
   end

   // Highest nonzero digit wins; an all-zero result still shows one digit.
   always_comb begin
      nd_calc = ND_W'(1);
      for (int unsigned i = 1; i < DIGITS; i++) begin
         if (bcd_next[4*i +: 4] != 4'd0) nd_calc = ND_W'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         bin_shift_q <= '0;
         bcd_work_q  <= '0;
         cnt_q       <= '0;
         bcd_out_q   <= '0;
         ndigits_q   <= ND_W'(1);
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  bin_shift_q <= bin_in;
                  bcd_work_q  <= '0;
                  cnt_q       <= CNT_W'(BIN_W);
                  state_q     <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_work_q  <= bcd_next;
               bin_shift_q <= bin_next;
               cnt_q       <= cnt_q - CNT_W'(1);
               // Result and digit count update together so the display never tears.
               if (cnt_q == CNT_W'(1)) begin
                  state_q   <= DONE;
                  bcd_out_q <= bcd_next;
                  ndigits_q <= nd_calc;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready   = (state_q == IDLE);
   assign busy    = (state_q == SHIFT);
   assign done    = (state_q == DONE);
   assign bcd_out = bcd_out_q;
   assign ndigits = ndigits_q;

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Scoreboard bench for bcd_convert_sequencer: accepted starts push hand-computed
// results; a negedge monitor checks handshake timing, results and hold behaviour.
module tb_bcd_convert_sequencer;

   localparam int unsigned BIN_W  = 31;
   localparam int unsigned DIGITS = 10;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [30:0] bin_in;
   logic        ready;
   logic        busy;
   logic        done;
   logic [39:0] bcd_out;
   logic [3:0]  ndigits;

   bcd_convert_sequencer #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .start   (start),
      .bin_in  (bin_in),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out),
      .ndigits (ndigits)
   );

   typedef struct {
      logic [39:0] bcd;
      logic [3:0]  nd;
      int          done_cyc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   acc_cnt = 0;
   int   last_acc = 0;
   int   prev_acc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hand-computed conversions for every value the stimulus applies.
   function automatic bit lookup(input logic [30:0] b, output logic [39:0] bcd,
                                 output logic [3:0] nd);
      lookup = 1'b1;
      case (b)
         31'd0:          begin bcd = 40'h0;          nd = 4'd1;  end
         31'd255:        begin bcd = 40'h255;        nd = 4'd3;  end
         31'd2147483647: begin bcd = 40'h2147483647; nd = 4'd10; end
         31'd1000000000: begin bcd = 40'h1000000000; nd = 4'd10; end
         31'd9999:       begin bcd = 40'h9999;       nd = 4'd4;  end
         31'd5:          begin bcd = 40'h5;          nd = 4'd1;  end
         31'd42:         begin bcd = 40'h42;         nd = 4'd2;  end
         31'd7:          begin bcd = 40'h7;          nd = 4'd1;  end
         31'd12:         begin bcd = 40'h12;         nd = 4'd2;  end
         default:        begin bcd = 40'h0; nd = 4'd0; lookup = 1'b0; end
      endcase
   endfunction

   // Acceptor: a start seen with ready before the edge is captured on that edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [39:0] b;
      logic [3:0]  n;
      if (resetn && ready && start) begin
         acc_cnt++;
         prev_acc = last_acc;
         last_acc = cyc + 1;
         if (!lookup(bin_in, b, n)) begin
            n_tests++;
            n_fail++;
            $display("FAIL vector: bin_in %0d has no expected value", bin_in);
         end
         e.bcd      = b;
         e.nd       = n;
         e.done_cyc = cyc + 1 + BIN_W;
         q.push_back(e);
      end
   end

   // Monitor: checks control outputs every cycle, results on done, hold otherwise.
   logic [39:0] held    = '0;
   logic [3:0]  held_nd = 4'd1;
   always @(negedge clk) begin
      exp_t e;
      bit   eb, ed;
      if (!resetn) begin
         held    = '0;
         held_nd = 4'd1;
         check("reset_ctl", {61'd0, ready, busy, done}, 64'b100);
         check("reset_bcd", 64'(bcd_out), 64'd0);
         check("reset_nd", 64'(ndigits), 64'd1);
      end else begin
         eb = (q.size() > 0) && (cyc >= q[0].done_cyc - BIN_W) && (cyc < q[0].done_cyc);
         ed = (q.size() > 0) && (cyc == q[0].done_cyc);
         check("ctl", {61'd0, ready, busy, done}, {61'd0, !eb && !ed, eb, ed});
         if (done) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1, expected no pending conversion");
            end else begin
               e = q.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.done_cyc));
               check("bcd_out", 64'(bcd_out), 64'(e.bcd));
               check("ndigits", 64'(ndigits), 64'(e.nd));
               held    = e.bcd;
               held_nd = e.nd;
            end
         end else begin
            if (q.size() > 0 && cyc > q[0].done_cyc) begin
               n_tests++;
               n_fail++;
               $display("FAIL done_timeout: got no done by cycle %0d, expected at %0d",
                        cyc, q[0].done_cyc);
               void'(q.pop_front());
            end
            check("bcd_hold", 64'(bcd_out), 64'(held));
            check("nd_hold", 64'(ndigits), 64'(held_nd));
         end
      end
   end

   task automatic wait_accept();
      int n = acc_cnt;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (acc_cnt != n) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accepted start, expected one within 100 cycles");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (q.size() == 0 && ready) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy/pending, expected idle within 100 cycles");
   endtask

   task automatic convert(input logic [30:0] b);
      bin_in = b;
      start  = 1'b1;
      wait_accept();
      start  = 1'b0;
      bin_in = 31'h1234567;  // later changes must not affect the captured value
      wait_idle();
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;

      convert(31'd0);
      convert(31'd255);
      convert(31'd2147483647);
      convert(31'd1000000000);

      // Starts while busy/done are ignored; the held 9999 stays until the next result.
      bin_in = 31'd9999;
      start  = 1'b1;
      wait_accept();
      bin_in = 31'd5;
      wait_accept();
      start  = 1'b0;
      wait_idle();

      // Reset in the 15th busy cycle abandons the conversion.
      bin_in = 31'd255;
      start  = 1'b1;
      wait_accept();
      start  = 1'b0;
      repeat (14) begin
         @(posedge clk);
         #1;
      end
      check("busy_before_reset", 64'(busy), 64'd1);
      resetn = 1'b0;
      q.delete();
      #1;
      check("async_reset_ctl", {61'd0, ready, busy, done}, 64'b100);
      check("async_reset_bcd", 64'(bcd_out), 64'd0);
      check("async_reset_nd", 64'(ndigits), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      convert(31'd42);

      // Start held high: back-to-back conversions every BIN_W+2 cycles.
      bin_in = 31'd7;
      start  = 1'b1;
      wait_accept();
      bin_in = 31'd12;
      wait_accept();
      check("b2b_gap", 64'(last_acc - prev_acc), 64'(BIN_W + 2));
      start = 1'b0;
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
